// File: rtl/pipelined_f2i.sv
// Three-stage IEEE-754 single -> signed int32 converter.
// Stage 1 decodes and classifies the operand, stage 2 aligns it into an
// integer magnitude plus guard/sticky bits, and stage 3 rounds, range-checks
// and packs the two's-complement result.
//
// Handshake: there is no ready. A slot is accepted on every rising edge with
// e = 1 and carries in_valid along with it. When e = 0 every register holds,
// including the outputs. out_valid marks a slot holding a real result;
// bubbles travel through as out_valid = 0.
module pipelined_f2i (
    input  logic        clk,
    input  logic        clrn,
    input  logic        e,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [1:0]  rm,
    output logic        out_valid,
    output logic [31:0] d,
    output logic        invalid,
    output logic        inexact
);

    // ---------------- stage 1: decode ----------------
    logic [7:0]  s1_exp;
    logic [23:0] s1_frac;
    logic        s1_nan, s1_inf, s1_ovf;

    assign s1_exp  = a[30:23];
    assign s1_frac = {|s1_exp, a[22:0]};
    assign s1_nan  = (s1_exp == 8'hFF) & (|a[22:0]);
    assign s1_inf  = (s1_exp == 8'hFF) & ~(|a[22:0]);
    // -2^31 is the one value at exponent 158 that still fits in int32
    assign s1_ovf  = (s1_exp >= 8'd158) & (a != 32'hCF00_0000);

    logic        p1_valid, p1_sign, p1_nan, p1_inf, p1_ovf;
    logic [7:0]  p1_exp;
    logic [23:0] p1_frac;
    logic [1:0]  p1_rm;

    // P1 register: decoded operand fields
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            p1_valid <= 1'b0;
            p1_sign  <= 1'b0;
            p1_nan   <= 1'b0;
            p1_inf   <= 1'b0;
            p1_ovf   <= 1'b0;
            p1_exp   <= 8'd0;
            p1_frac  <= 24'd0;
            p1_rm    <= 2'd0;
        end else if (e) begin
            p1_valid <= in_valid;
            p1_sign  <= a[31];
            p1_nan   <= s1_nan;
            p1_inf   <= s1_inf;
            p1_ovf   <= s1_ovf;
            p1_exp   <= s1_exp;
            p1_frac  <= s1_frac;
            p1_rm    <= rm;
        end
    end

    // ---------------- stage 2: align ----------------
    logic [31:0] s2_mag;
    logic        s2_g, s2_s;
    logic [7:0]  s2_lsh, s2_rsh;
    logic [47:0] s2_ext;

    // Integer magnitude plus guard/sticky; exponents 126..149 share one right
    // shifter (shift 24 at E=126 leaves the hidden bit as the guard bit)
    always_comb begin
        s2_mag = 32'd0;
        s2_g   = 1'b0;
        s2_s   = 1'b0;
        s2_lsh = 8'd0;
        s2_rsh = 8'd0;
        s2_ext = 48'd0;
        if (p1_exp >= 8'd150) begin
            // values above 158 are flagged overflow, so the truncated shift is harmless
            s2_lsh = p1_exp - 8'd150;
            s2_mag = {8'd0, p1_frac} << s2_lsh;
        end else if (p1_exp >= 8'd126) begin
            s2_rsh = 8'd150 - p1_exp;
            s2_ext = {p1_frac, 24'd0} >> s2_rsh;
            s2_mag = {8'd0, s2_ext[47:24]};
            s2_g   = s2_ext[23];
            s2_s   = |s2_ext[22:0];
        end else begin
            s2_s   = |p1_frac;
        end
    end

    logic        p2_valid, p2_sign, p2_nan, p2_inf, p2_ovf, p2_g, p2_s;
    logic [31:0] p2_mag;
    logic [1:0]  p2_rm;

    // P2 register: aligned magnitude and rounding bits
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            p2_valid <= 1'b0;
            p2_sign  <= 1'b0;
            p2_nan   <= 1'b0;
            p2_inf   <= 1'b0;
            p2_ovf   <= 1'b0;
            p2_g     <= 1'b0;
            p2_s     <= 1'b0;
            p2_mag   <= 32'd0;
            p2_rm    <= 2'd0;
        end else if (e) begin
            p2_valid <= p1_valid;
            p2_sign  <= p1_sign;
            p2_nan   <= p1_nan;
            p2_inf   <= p1_inf;
            p2_ovf   <= p1_ovf;
            p2_g     <= s2_g;
            p2_s     <= s2_s;
            p2_mag   <= s2_mag;
            p2_rm    <= p1_rm;
        end
    end

    // ---------------- stage 3: round / pack ----------------
    logic        s3_inc, s3_rovf;
    logic [32:0] s3_r;
    logic [31:0] s3_d;
    logic        s3_invalid, s3_inexact;

    // Rounding increment, range check and final saturation/negation
    always_comb begin
        s3_inc     = 1'b0;
        s3_r       = 33'd0;
        s3_rovf    = 1'b0;
        s3_d       = 32'd0;
        s3_invalid = 1'b0;
        s3_inexact = 1'b0;
        case (p2_rm)
            2'b00:   s3_inc = p2_g & (p2_s | p2_mag[0]);
            2'b01:   s3_inc = p2_sign & (p2_g | p2_s);
            2'b10:   s3_inc = ~p2_sign & (p2_g | p2_s);
            default: s3_inc = 1'b0;
        endcase
        s3_r    = {1'b0, p2_mag} + {32'd0, s3_inc};
        s3_rovf = p2_sign ? (s3_r > 33'h0_8000_0000) : (s3_r > 33'h0_7FFF_FFFF);
        if (p2_nan) begin
            s3_d       = 32'h7FFF_FFFF;
            s3_invalid = 1'b1;
        end else if (p2_inf | p2_ovf | s3_rovf) begin
            s3_d       = p2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            s3_invalid = 1'b1;
        end else begin
            s3_d       = p2_sign ? (~s3_r[31:0] + 32'd1) : s3_r[31:0];
            s3_inexact = p2_g | p2_s;
        end
    end

    // Output register: result and flags, held while e = 0
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid <= 1'b0;
            d         <= 32'd0;
            invalid   <= 1'b0;
            inexact   <= 1'b0;
        end else if (e) begin
            out_valid <= p2_valid;
            d         <= s3_d;
            invalid   <= s3_invalid;
            inexact   <= s3_inexact;
        end
    end

endmodule

// File: tb/tb_pipelined_f2i.sv
// Self-checking bench for pipelined_f2i: directed corner cases, a stall
// sequence, randomized traffic and a mid-stream reset, all scored against an
// exact fixed-point model of float -> int32 conversion.
module tb_pipelined_f2i;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic        e = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = 32'd0;
    logic [1:0]  rm = 2'd0;
    logic        out_valid;
    logic [31:0] d;
    logic        invalid;
    logic        inexact;

    pipelined_f2i dut (
        .clk       (clk),
        .clrn      (clrn),
        .e         (e),
        .in_valid  (in_valid),
        .a         (a),
        .rm        (rm),
        .out_valid (out_valid),
        .d         (d),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0] d;
        logic        inv;
        logic        inx;
        int unsigned due;
    } exp_rec_t;

    exp_rec_t    exp_q[$];
    int unsigned en_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic        mon_en, mon_rst;
    logic        prev_valid, prev_invalid, prev_inexact;
    logic [31:0] prev_d;
    exp_rec_t    mon_x;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Scale |a| by 2^64 exactly, split into integer and fraction, round, then
    // range-check the signed value.
    function automatic exp_rec_t f2i_model(input logic [31:0] op, input logic [1:0] mode);
        exp_rec_t    r;
        logic        sign;
        logic [7:0]  ex;
        logic [23:0] f24;
        logic [127:0] scaled;
        logic [63:0] ip, fp;
        logic        up;
        longint      mag_l, val;
        r = '0;
        sign = op[31];
        ex   = op[30:23];
        f24  = {(ex != 8'd0), op[22:0]};
        if (ex == 8'hFF) begin
            r.inv = 1'b1;
            r.d   = (op[22:0] != 23'd0 || !sign) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else if (ex >= 8'd160) begin
            r.inv = 1'b1;
            r.d   = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            if (ex >= 8'd86) scaled = {104'd0, f24} << (ex - 8'd86);
            else             scaled = (f24 != 24'd0) ? 128'd1 : 128'd0;
            ip = scaled[127:64];
            fp = scaled[63:0];
            case (mode)
                2'b00:   up = (fp > 64'h8000_0000_0000_0000) ||
                              (fp == 64'h8000_0000_0000_0000 && ip[0]);
                2'b01:   up = sign && (fp != 64'd0);
                2'b10:   up = !sign && (fp != 64'd0);
                default: up = 1'b0;
            endcase
            mag_l = longint'(ip) + (up ? 64'sd1 : 64'sd0);
            val   = sign ? -mag_l : mag_l;
            if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
                r.inv = 1'b1;
                r.d   = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                r.d   = val[31:0];
                r.inx = (fp != 64'd0);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] op;
        case ($urandom_range(0, 3))
            0:       op = $urandom();
            1, 2:    op = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 160)), 23'($urandom())};
            default: op = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 140)),
                           23'($urandom()) & 23'h7F0000};
        endcase
        return op;
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; an enabled edge records the expected
    // result due two enabled edges later.
    task automatic step(input logic ev, input logic vld, input logic [31:0] op,
                        input logic [1:0] mode, input exp_rec_t x);
        exp_rec_t y;
        @(negedge clk);
        e = ev; in_valid = vld; a = op; rm = mode;
        if (ev && clrn) begin
            en_cnt++;
            if (vld) begin
                y = x;
                y.due = en_cnt + 2;
                exp_q.push_back(y);
            end
        end
    endtask

    task automatic drive_dir(input logic [31:0] op, input logic [1:0] mode,
                             input logic [31:0] dv, input logic inv, input logic inx);
        exp_rec_t x;
        x = '0;
        x.d = dv; x.inv = inv; x.inx = inx;
        step(1'b1, 1'b1, op, mode, x);
    endtask

    task automatic drive_op(input logic [31:0] op, input logic [1:0] mode);
        step(1'b1, 1'b1, op, mode, f2i_model(op, mode));
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 2'd0, '0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_d"}, d, 32'd0);
        check({tag, "_invalid"}, {31'd0, invalid}, 32'd0);
        check({tag, "_inexact"}, {31'd0, inexact}, 32'd0);
    endtask

    // ---------------- monitor ----------------
    // Enabled edge: either the head result is due or the slot must be a bubble.
    // Disabled edge: all outputs must hold.
    always @(posedge clk) begin
        mon_en  = e;
        mon_rst = !clrn;
        #1;
        if (!mon_rst) begin
            if (mon_en) begin
                if (exp_q.size() > 0 && exp_q[0].due == en_cnt) begin
                    mon_x = exp_q.pop_front();
                    check("out_valid", {31'd0, out_valid}, 32'd1);
                    check("d", d, mon_x.d);
                    check("invalid", {31'd0, invalid}, {31'd0, mon_x.inv});
                    check("inexact", {31'd0, inexact}, {31'd0, mon_x.inx});
                end else begin
                    check("bubble_valid", {31'd0, out_valid}, 32'd0);
                end
            end else begin
                check("hold_valid", {31'd0, out_valid}, {31'd0, prev_valid});
                check("hold_d", d, prev_d);
                check("hold_invalid", {31'd0, invalid}, {31'd0, prev_invalid});
                check("hold_inexact", {31'd0, inexact}, {31'd0, prev_inexact});
            end
        end
        prev_valid   = out_valid;
        prev_d       = d;
        prev_invalid = invalid;
        prev_inexact = inexact;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic        ev, vld;
        logic [31:0] op;
        logic [1:0]  mode;

        #2 clrn = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1; e = 1'b0; in_valid = 1'b0;

        // directed corner cases
        drive_dir(32'h3FC0_0000, 2'b00, 32'd2,          1'b0, 1'b1);
        drive_dir(32'h3FC0_0000, 2'b11, 32'd1,          1'b0, 1'b1);
        drive_dir(32'h4020_0000, 2'b00, 32'd2,          1'b0, 1'b1);
        drive_dir(32'hBFC0_0000, 2'b01, 32'hFFFF_FFFE,  1'b0, 1'b1);
        drive_dir(32'hBFC0_0000, 2'b10, 32'hFFFF_FFFF,  1'b0, 1'b1);
        drive_dir(32'hCF00_0000, 2'b00, 32'h8000_0000,  1'b0, 1'b0);
        drive_dir(32'h4F00_0000, 2'b00, 32'h7FFF_FFFF,  1'b1, 1'b0);
        drive_dir(32'h4EFF_FFFF, 2'b00, 32'h7FFF_FF80,  1'b0, 1'b0);
        drive_dir(32'h7FC0_0000, 2'b00, 32'h7FFF_FFFF,  1'b1, 1'b0);
        drive_dir(32'hFF80_0000, 2'b00, 32'h8000_0000,  1'b1, 1'b0);
        drive_dir(32'h8000_0000, 2'b00, 32'd0,          1'b0, 1'b0);
        drive_dir(32'h0000_0001, 2'b10, 32'd1,          1'b0, 1'b1);
        drive_dir(32'h0000_0001, 2'b00, 32'd0,          1'b0, 1'b1);
        drive_dir(32'hCF00_0001, 2'b11, 32'h8000_0000,  1'b1, 1'b0);
        drain();

        // stall in the middle of a burst
        drive_op(32'h3F80_0000, 2'b00);
        drive_op(32'h4000_0000, 2'b00);
        step(1'b0, 1'b0, 32'd0, 2'd0, '0);
        step(1'b0, 1'b0, 32'd0, 2'd0, '0);
        drive_op(32'h4040_0000, 2'b00);
        step(1'b1, 1'b0, 32'd0, 2'd0, '0);
        step(1'b0, 1'b0, 32'd0, 2'd0, '0);
        step(1'b0, 1'b0, 32'd0, 2'd0, '0);
        drain();

        // randomized traffic with random stalls and bubbles
        for (int i = 0; i < 500; i++) begin
            ev   = ($urandom_range(0, 9) < 8);
            vld  = ($urandom_range(0, 3) != 0);
            op   = rand_op();
            mode = 2'($urandom_range(0, 3));
            step(ev, vld, op, mode, f2i_model(op, mode));
        end
        drain();

        // reset with two operands in flight
        drive_op(32'h4120_0000, 2'b00);
        drive_op(32'hC0A0_0000, 2'b00);
        @(negedge clk);
        clrn = 1'b0; in_valid = 1'b0;
        #1 check_zero_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1; e = 1'b0;
        drive_op(32'h42F6_0000, 2'b00);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipelined_f2i.md
# pipelined_f2i

Three-stage pipelined converter from IEEE-754 single precision to signed 32-bit integer. It reads the same 32-bit float format the pipelined FP adder writes, and uses the same `rm` encoding and enable-stall discipline, so adder results can be converted in the FPU execute pipeline. Each pipeline stage advances only when `e` is high. A valid bit travels with each operand.

## Interface
- No parameters.
- `clk` input 1: clock; all state updates on the rising edge.
- `clrn` input 1: reset, asynchronous, active-low.
- `e` input 1: pipeline enable. 1 = all stages advance; 0 = all stages hold.
- `in_valid` input 1: `a`/`rm` carry a real operand this cycle.
- `a` input 32: IEEE-754 single-precision operand.
- `rm` input 2: rounding mode.
  - 00 = nearest-even
  - 01 = toward −inf
  - 10 = toward +inf
  - 11 = toward zero
- `out_valid` output 1: `d` and flags hold a completed result.
- `d` output 32: two's-complement integer result.
- `invalid` output 1: operand was NaN, ±inf, or out of int32 range.
- `inexact` output 1: the result differs from the operand value; never set together with `invalid`.

## Operation
- **Stage 1 (decode), registered into P1:**
  - Extract sign, exponent `E[7:0]` and `frac24 = {|E, a[22:0]}`.
  - Classify: `nan = (E==FF) & (frac≠0)`; `inf = (E==FF) & (frac==0)`.
  - Overflow: `ovf = (E≥158)` except the exact value 0xCF000000 (−2^31).
  - Carry `rm` and `valid` with the operand.
- **Stage 2 (align), registered into P2:**
  - Produce the 32-bit magnitude `mag = floor(|a|)`, guard bit `g` (first fraction bit) and sticky bit `s` (OR of all lower bits).
  - E in 150..157: `mag = frac24 << (E−150)`; `g = s = 0`.
  - E in 127..149: `mag = frac24 >> (150−E)`; `g` and `s` taken from the bits shifted out.
  - E = 126: `mag = 0`; `g = 1`; `s = |frac[22:0]`.
  - E < 126, including zero and denormals: `mag = 0`; `g = 0`; `s = |frac24`.
  - Carry sign, `rm`, `nan`, `inf`, `ovf` and `valid`.
- **Stage 3 (round/pack), registered into the output registers:**
  - Round increment `inc`:
    - rm 00: `g & (s | mag[0])`
    - rm 01: `sign & (g | s)`
    - rm 10: `~sign & (g | s)`
    - rm 11: 0
  - `r = mag + inc`, computed 33 bits wide.
  - Range overflow `rovf`: positive with `r > 2^31−1`, or negative with `r > 2^31`.
  - `nan` → `d = 0x7FFFFFFF`, `invalid = 1`.
  - `inf`, `ovf` or `rovf` → `d = 0x7FFFFFFF` if positive, `0x80000000` if negative; `invalid = 1`.
  - Otherwise `d = sign ? −r : r`, `invalid = 0`, `inexact = g | s`.
  - −0.0 gives `d = 0`.
- `out_valid` is the stage-3 copy of `in_valid`.
- Stage registers load whenever `e = 1`, independent of valid, so bubbles propagate as invalid slots.

## Timing
- Latency is 3 enabled edges. An operand sampled at enabled edge k appears on `d`/`out_valid` after enabled edge k+2 and stays there until the next enabled edge.
- Throughput is 1 operand per enabled cycle.
- `e = 0`: every register, including the outputs, holds its value. There is no internal stall or back-pressure.
- Reset (`clrn = 0`), asynchronous:
  - all P1, P2 and output registers clear to 0;
  - `out_valid = 0`, `d = 0x00000000`, `invalid = 0`, `inexact = 0`.
- Reset mid-stream discards all in-flight operands. The first result after reset is the first operand sampled after `clrn` rises.
- Reset has priority over `e`.
- Outputs are driven only from registers; there is no combinational path from `a` to `d`.

## Test plan
- **Rounding of halves:**
  - 0x3FC00000 (1.5), rm 00 → `d = 2`, `inexact = 1`.
  - Same operand, rm 11 → `d = 1`.
  - 0x40200000 (2.5), rm 00 → `d = 2`, `inexact = 1`.
- **Negative directed rounding:**
  - 0xBFC00000 (−1.5), rm 01 → `d = 0xFFFFFFFE`.
  - Same operand, rm 10 → `d = 0xFFFFFFFF`.
  - Both cases `inexact = 1`.
- **Range limits:**
  - 0xCF000000 → `d = 0x80000000`, `invalid = 0`, `inexact = 0`.
  - 0x4F000000 → `d = 0x7FFFFFFF`, `invalid = 1`.
  - 0x4EFFFFFF → `d = 0x7FFFFF80`, `invalid = 0`.
- **Specials:**
  - 0x7FC00000 → `d = 0x7FFFFFFF`, `invalid = 1`.
  - 0xFF800000 → `d = 0x80000000`, `invalid = 1`.
  - 0x80000000 → `d = 0`, both flags 0.
  - 0x00000001, rm 10 → `d = 1`, `inexact = 1`.
  - 0x00000001, rm 00 → `d = 0`, `inexact = 1`.
- **Pipeline:**
  - Stimulus: three back-to-back valid operands (1.0, 2.0, 3.0) with `e = 0` for 2 cycles after the second.
  - Required: results 1, 2, 3 in order; each held during the stall; `out_valid` high exactly 3 enabled cycles.
- **Reset:**
  - Stimulus: assert `clrn = 0` while 2 operands are in flight.
  - Required: outputs clear immediately; no stale result appears after `clrn` rises; a new operand emerges after 3 enabled edges.
